window_gen_kxk: RTL
===================

Name: window_gen_kxk

Overview:
- Parameterised K×K sliding-window generator for raster-scan pixel streams; generalises the fixed 7×7 line-buffer kernel to any odd K and any image width and height.
- Tracks row and column position, so Valid_OUT asserts only for windows lying fully inside the image. No windows straddle a row wrap or a frame boundary.
- Outputs a Frame_Done pulse.
- Sits between the pixel source and the convolution/filter datapath.

Parameters:
- K, 7, window size; odd, 3..15.
- IMG_Width, 8, pixels per row; must be ≥ K.
- IMG_Height, 8, rows per frame; must be ≥ K.
- Datawidth, 8, bits per pixel.
- CW, $clog2(IMG_Width) (min 1), column index width.
- RW, $clog2(IMG_Height) (min 1), row index width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- CLR  input  1  synchronous reset, active-high.
- In  input  Datawidth  pixel, raster order.
- Valid_IN  input  1  In is valid this cycle; pixel accepted at this edge.
- Window  output  K*K*Datawidth  flattened window.
  - Tap (r,c) occupies bits [(r*K+c+1)*Datawidth-1 : (r*K+c)*Datawidth].
  - r=0 is the oldest (top) row; c=0 is the oldest (left) column.
  - Tap (K-1,K-1) is the most recent pixel.
- Valid_OUT  output  1  Window is a complete in-image window.
- Row_Idx  output  RW  row of the pixel at tap (K-1,K-1).
- Col_Idx  output  CW  column of the pixel at tap (K-1,K-1).
- Frame_Done  output  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset: CLR=1 at an edge clears the following to 0:
  - all window registers (Window=0),
  - Valid_OUT, Frame_Done, Row_Idx, Col_Idx,
  - internal column/row counters and line-buffer pointer.
- Reset is not applied to line-buffer RAM; its contents are don't-care. CLR has priority over Valid_IN.
- Structure:
  - K-1 line buffers, each IMG_Width deep, implemented as a circular RAM with one shared write/read pointer (not a register chain).
  - K rows of K-deep tap shift registers.
  - Bottom tap row is fed from In; tap row r is fed from line buffer output r (read-before-write at the pointer).
- On accepted pixel (Valid_IN=1, CLR=0), all of the following happen at that edge:
  - All K tap rows shift left by one. Column K-1 loads the new pixel (bottom row) or the line-buffer read data (other rows).
  - Line buffers write the chain; the pointer increments and wraps from IMG_Width-1 to 0.
  - Column counter x increments. At IMG_Width-1 it wraps to 0 and row counter y increments. At (IMG_Height-1, IMG_Width-1) both wrap to 0.
  - Row_Idx/Col_Idx register the (y,x) of the accepted pixel.
  - Valid_OUT <= (y ≥ K-1) && (x ≥ K-1).
  - Frame_Done <= (y == IMG_Height-1) && (x == IMG_Width-1).
- Latency: Window, Valid_OUT, Row_Idx and Col_Idx reflect the pixel accepted at edge N, visible after edge N (1 cycle).
- Stall (Valid_IN=0): no shift, no pointer or counter change. Window, Row_Idx and Col_Idx hold. Valid_OUT and Frame_Done go 0 at the next edge. Each accepted pixel yields at most one Valid_OUT cycle.
- Valid windows per frame: (IMG_Width-K+1)*(IMG_Height-K+1). Windows ending at x<K-1 (row wrap) are suppressed, as are windows with y<K-1.
- Frame boundary:
  - Frames run back-to-back with no gap cycle required.
  - Stale rows from the previous frame sit in the line buffers during rows 0..K-2 of the next frame. This is harmless because Valid_OUT is suppressed there.
  - No flush is performed.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of a new frame.
- No backpressure: the consumer must accept every Valid_OUT cycle.

Test Plan:
- K=7, 8×8, pixel=y*8+x, continuous Valid_IN:
  - First Valid_OUT after the 55th pixel (value 54), with tap(0,0)=0, tap(0,6)=6, tap(6,0)=48, tap(6,6)=54, Row_Idx=6, Col_Idx=6.
  - Exactly 4 Valid_OUT cycles per frame.
- Same stream, row wrap:
  - Valid_OUT=1 after pixel 55 (6,7).
  - Valid_OUT=0 after pixels 56..61, i.e. (7,0)..(7,5).
  - Valid_OUT=1 after pixel 62 (7,6), with tap(0,0)=8.
- Random Valid_IN gaps (≈30% idle) → the Window/Row_Idx/Col_Idx sequence at Valid_OUT cycles is identical to the continuous run; Window holds during gaps.
- Two frames back-to-back, second frame pixel=100+y*8+x:
  - Frame_Done pulses exactly with the window of pixel 63 each frame.
  - The second frame's first valid window has tap(0,0)=100 and tap(6,6)=154, with no stale data.
- CLR for one cycle after 30 pixels (Valid_IN=1 during CLR):
  - Next cycle Window=0, Valid_OUT=0, Row_Idx=0, Col_Idx=0.
  - A fresh frame then yields its first valid window at its 55th pixel.
- K=3, IMG_Width=5, IMG_Height=4, pixel=y*5+x:
  - 6 valid windows.
  - First window is taps 0,1,2 / 5,6,7 / 10,11,12, with Row_Idx=2, Col_Idx=2.

Source files
------------

// File: rtl/window_gen_kxk.sv
// K x K sliding-window generator for raster pixel streams; windows are emitted only when fully inside the image.
// One-cycle latency from accepted pixel to Window/Valid_OUT; no backpressure, Valid_IN=0 simply stalls.
module window_gen_kxk #(
  parameter int K          = 7,
  parameter int IMG_Width  = 8,
  parameter int IMG_Height = 8,
  parameter int Datawidth  = 8,
  parameter int CW         = (IMG_Width  > 1) ? $clog2(IMG_Width)  : 1,
  parameter int RW         = (IMG_Height > 1) ? $clog2(IMG_Height) : 1
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic [Datawidth-1:0]       In,
  input  logic                       Valid_IN,
  output logic [K*K*Datawidth-1:0]   Window,
  output logic                       Valid_OUT,
  output logic [RW-1:0]              Row_Idx,
  output logic [CW-1:0]              Col_Idx,
  output logic                       Frame_Done
);

  localparam logic [CW-1:0] X_LAST  = CW'(IMG_Width - 1);
  localparam logic [RW-1:0] Y_LAST  = RW'(IMG_Height - 1);
  localparam logic [CW-1:0] X_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] Y_FIRST = RW'(K - 1);

  logic [Datawidth-1:0] lb_mem [K-1][IMG_Width];
  logic [Datawidth-1:0] row_feed [K];
  logic [Datawidth-1:0] taps [K][K];
  logic [CW-1:0]        ptr;
  logic [CW-1:0]        x;
  logic [RW-1:0]        y;
  logic                 accept;

  assign accept = Valid_IN & ~CLR;

  // Entry K-1 is the live pixel; entry r is line buffer r, read before this edge's write.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      row_feed[r] = lb_mem[r][ptr];
    end
    row_feed[K-1] = In;
  end

  // Each buffer takes the row below it, so buffer 0 holds the pixel K-1 rows back.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int r = 0; r < K - 1; r++) begin
        lb_mem[r][ptr] <= row_feed[r+1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          taps[r][c] <= '0;
        end
      end
      ptr        <= '0;
      x          <= '0;
      y          <= '0;
      Row_Idx    <= '0;
      Col_Idx    <= '0;
      Valid_OUT  <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      Valid_OUT  <= 1'b0;
      Frame_Done <= 1'b0;
      if (Valid_IN) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            taps[r][c] <= taps[r][c+1];
          end
          taps[r][K-1] <= row_feed[r];
        end
        ptr <= (ptr == X_LAST) ? '0 : ptr + CW'(1);
        x   <= (x == X_LAST) ? '0 : x + CW'(1);
        if (x == X_LAST) begin
          y <= (y == Y_LAST) ? '0 : y + RW'(1);
        end
        Row_Idx    <= y;
        Col_Idx    <= x;
        Valid_OUT  <= (y >= Y_FIRST) && (x >= X_FIRST);
        Frame_Done <= (y == Y_LAST) && (x == X_LAST);
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign Window[(r*K+c)*Datawidth +: Datawidth] = taps[r][c];
    end
  end

endmodule
